// File: rtl/dda_oscillator_bank.sv
// Multi-channel symplectic-Euler sin/cos oscillator bank sharing one multiplier.
module dda_oscillator_bank #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned FRAC_BITS      = 62,
    parameter int unsigned TIME_WIDTH     = 8,
    parameter int unsigned TIME_SCALE_POW = 8,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [CH_W-1:0]       load_ch,
    input  logic [DATA_WIDTH-1:0] sin_y0,
    input  logic [DATA_WIDTH-1:0] cos_y0,
    input  logic [TIME_WIDTH-1:0] k_in,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  n_steps,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [CH_W-1:0]       out_ch,
    output logic [CNT_WIDTH-1:0]  out_step,
    output logic [DATA_WIDTH-1:0] sin_y,
    output logic [DATA_WIDTH-1:0] cos_y
);

    localparam int unsigned PW      = DATA_WIDTH + TIME_WIDTH;
    localparam int unsigned SW      = PW + 1;
    localparam int unsigned LAST_CH = NUM_CH - 1;

    // Reject parameter sets the fixed-point format cannot represent
    if (NUM_CH < 1 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
        $error("dda_oscillator_bank: invalid NUM_CH or FRAC_BITS");
    end

    typedef enum logic [1:0] {IDLE, UPD_C, UPD_S} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   sin_r [NUM_CH];
    logic [DATA_WIDTH-1:0]   cos_r [NUM_CH];
    logic [TIME_WIDTH-1:0]   k_r   [NUM_CH];
    logic [CH_W-1:0]         ch, ch_next;
    logic [CNT_WIDTH-1:0]    step, step_next;
    logic [CNT_WIDTH-1:0]    n_lat, n_lat_next;
    logic                    busy_next, done_next, out_valid_next;
    logic                    load_we, cos_we, sin_we;

    logic [DATA_WIDTH-1:0]   mul_a;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    shifted;
    logic signed [SW-1:0]    acc;
    logic [DATA_WIDTH-1:0]   sat_res;

    // Clamp a widened sum back into the signed DATA_WIDTH range
    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        logic [SW-DATA_WIDTH:0] upper;
        upper = v[SW-1:DATA_WIDTH-1];
        if (upper == '0 || upper == '1) begin
            return v[DATA_WIDTH-1:0];
        end else if (v[SW-1]) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    // Shared multiplier: sin*k while updating cos, new cos*k while updating sin
    always_comb begin
        mul_a   = (state == UPD_S) ? cos_r[ch] : sin_r[ch];
        prod    = PW'($signed(mul_a)) * PW'($signed(k_r[ch]));
        shifted = prod >>> TIME_SCALE_POW;
        acc     = (state == UPD_S) ? SW'($signed(sin_r[ch])) + SW'(shifted)
                                   : SW'($signed(cos_r[ch])) - SW'(shifted);
        sat_res = sat(acc);
    end

    // Next-state and control decode
    always_comb begin
        state_next     = state;
        ch_next        = ch;
        step_next      = step;
        n_lat_next     = n_lat;
        busy_next      = busy;
        done_next      = 1'b0;
        out_valid_next = 1'b0;
        load_we        = 1'b0;
        cos_we         = 1'b0;
        sin_we         = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    load_we = (32'(load_ch) < NUM_CH);
                end else if (start) begin
                    if (n_steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        n_lat_next = n_steps;
                        ch_next    = '0;
                        step_next  = CNT_WIDTH'(1);
                        busy_next  = 1'b1;
                        state_next = UPD_C;
                    end
                end
            end
            UPD_C: begin
                cos_we     = 1'b1;
                state_next = UPD_S;
            end
            UPD_S: begin
                sin_we         = 1'b1;
                out_valid_next = 1'b1;
                if (32'(ch) < LAST_CH) begin
                    ch_next    = ch + CH_W'(1);
                    state_next = UPD_C;
                end else if (step < n_lat) begin
                    ch_next    = '0;
                    step_next  = step + CNT_WIDTH'(1);
                    state_next = UPD_C;
                end else begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ch        <= '0;
            step      <= '0;
            n_lat     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_step  <= '0;
            sin_y     <= '0;
            cos_y     <= '0;
        end else begin
            state     <= state_next;
            ch        <= ch_next;
            step      <= step_next;
            n_lat     <= n_lat_next;
            busy      <= busy_next;
            done      <= done_next;
            out_valid <= out_valid_next;
            if (out_valid_next) begin
                out_ch   <= ch;
                out_step <= step;
                sin_y    <= sat_res;
                cos_y    <= cos_r[ch];
            end
        end
    end

    // Per-channel oscillator state and coefficients
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sin_r[i] <= '0;
                cos_r[i] <= '0;
                k_r[i]   <= '0;
            end
        end else begin
            if (load_we) begin
                sin_r[load_ch] <= sin_y0;
                cos_r[load_ch] <= cos_y0;
                k_r[load_ch]   <= k_in;
            end
            if (cos_we) begin
                cos_r[ch] <= sat_res;
            end
            if (sin_we) begin
                sin_r[ch] <= sat_res;
            end
        end
    end

endmodule

// File: tb/tb_dda_oscillator_bank.sv
// Scoreboard bench for dda_oscillator_bank: 16-bit state, 4 channels.
module tb_dda_oscillator_bank;

    localparam int DW = 16;
    localparam int TW = 8;
    localparam int TSP = 8;
    localparam int NCH = 4;
    localparam int CW = 16;
    localparam int CHW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [CHW-1:0] load_ch = '0;
    logic [DW-1:0] sin_y0 = '0;
    logic [DW-1:0] cos_y0 = '0;
    logic [TW-1:0] k_in = '0;
    logic          start = 1'b0;
    logic [CW-1:0] n_steps = '0;
    logic          busy, done, out_valid;
    logic [CHW-1:0] out_ch;
    logic [CW-1:0] out_step;
    logic [DW-1:0] sin_y, cos_y;

    dda_oscillator_bank #(
        .DATA_WIDTH(DW), .FRAC_BITS(14), .TIME_WIDTH(TW), .TIME_SCALE_POW(TSP),
        .NUM_CH(NCH), .CNT_WIDTH(CW), .CH_W(CHW)
    ) dut (
        .clk(clk), .reset(rst_n), .load(load), .load_ch(load_ch),
        .sin_y0(sin_y0), .cos_y0(cos_y0), .k_in(k_in), .start(start),
        .n_steps(n_steps), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ch(out_ch), .out_step(out_step), .sin_y(sin_y), .cos_y(cos_y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     ch;
        int     step;
        longint s;
        longint c;
        bit     last;
        bit     done_only;
    } exp_t;

    exp_t   q[$];
    longint ms[NCH];
    longint mc[NCH];
    longint mk[NCH];
    int     n_checks = 0;
    int     n_fail = 0;
    longint last0_s = 0;
    longint last0_c = 0;
    bit     amp_watch = 1'b0;
    longint amp_min = 64'h7fffffffffffffff;
    longint amp_max = 0;
    bit     sat_seen = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: run n steps of the oscillator equations over all channels
    task automatic model_run(input int n);
        exp_t e;
        if (n == 0) begin
            e = '{ch: 0, step: 0, s: 0, c: 0, last: 1'b1, done_only: 1'b1};
            q.push_back(e);
        end
        for (int st = 1; st <= n; st++) begin
            for (int c = 0; c < NCH; c++) begin
                mc[c] = sat(mc[c] - ((ms[c] * mk[c]) >>> TSP));
                ms[c] = sat(ms[c] + ((mc[c] * mk[c]) >>> TSP));
                e = '{ch: c, step: st, s: ms[c], c: mc[c],
                      last: (st == n && c == NCH - 1), done_only: 1'b0};
                q.push_back(e);
            end
        end
    endtask

    // Monitor: every out_valid/done is matched against the next expected entry
    always @(negedge clk) begin
        exp_t e;
        longint a;
        if (rst_n && (out_valid || done)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q.pop_front();
                if (e.done_only) begin
                    chk("zero_run_done", longint'(done), 1);
                    chk("zero_run_no_valid", longint'(out_valid), 0);
                end else begin
                    chk("out_valid", longint'(out_valid), 1);
                    chk("out_ch", longint'(out_ch), e.ch);
                    chk("out_step", longint'(out_step), e.step);
                    chk("sin_y", sx(sin_y), e.s);
                    chk("cos_y", sx(cos_y), e.c);
                    chk("done_with_last", longint'(done), longint'(e.last));
                end
            end
        end
        if (rst_n && out_valid && out_ch == 2'd0) begin
            last0_s = sx(sin_y);
            last0_c = sx(cos_y);
            if (amp_watch) begin
                a = last0_s * last0_s + last0_c * last0_c;
                if (a < amp_min) amp_min = a;
                if (a > amp_max) amp_max = a;
                if (last0_s == 32767 || last0_s == -32768 ||
                    last0_c == 32767 || last0_c == -32768) sat_seen = 1'b1;
            end
        end
    end

    task automatic do_load(input int ch, input logic [DW-1:0] s, input logic [DW-1:0] c,
                           input logic [TW-1:0] k);
        @(negedge clk);
        load = 1'b1; load_ch = CHW'(ch); sin_y0 = s; cos_y0 = c; k_in = k;
        @(negedge clk);
        load = 1'b0;
        ms[ch] = sx(s); mc[ch] = sx(c); mk[ch] = longint'($signed(k));
    endtask

    // Start a run, check done latency and busy length; optionally poke load/start mid-run
    task automatic do_run(input int n, input bit poke);
        int  cyc = 0;
        int  bc = 0;
        int  t = 2 * NCH * n;
        bit  got = 1'b0;
        model_run(n);
        @(negedge clk);
        start = 1'b1; n_steps = CW'(n);
        for (int i = 0; i < t + 50; i++) begin
            @(negedge clk);
            start = 1'b0; load = 1'b0;
            cyc++;
            if (busy) bc++;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (poke && cyc == 3) begin
                load = 1'b1; start = 1'b1; n_steps = 16'd7;
                load_ch = 2'd0; sin_y0 = 16'h1234; cos_y0 = 16'h4321; k_in = 8'h55;
            end
        end
        chk("run_done_latency", got ? longint'(cyc) : -1, longint'(t + 1));
        chk("run_busy_cycles", longint'(bc), longint'(t));
    endtask

    initial begin
        int found;
        for (int i = 0; i < NCH; i++) begin
            ms[i] = 0; mc[i] = 0; mk[i] = 0;
        end
        #23 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_valid", longint'(out_valid), 0);
        chk("reset_sin", longint'(sin_y), 0);
        chk("reset_cos", longint'(cos_y), 0);
        chk("reset_step", longint'(out_step), 0);

        // Basic single oscillator on ch0
        do_load(0, 16'd0, 16'd16384, 8'd16);
        do_run(2, 1'b0);
        chk("basic_sin_step2", last0_s, 2044);
        chk("basic_cos_step2", last0_c, 16320);

        // Saturation, positive and negative
        do_load(0, 16'd32767, 16'd32767, 8'd127);
        do_run(1, 1'b0);
        chk("sat_pos_cos", last0_c, 16512);
        chk("sat_pos_sin", last0_s, 32767);
        do_load(0, 16'h8000, 16'h8000, 8'd127);
        do_run(1, 1'b0);
        chk("sat_neg_sin", last0_s, -32768);

        // Four channels with distinct k
        do_load(0, 16'd0, 16'd16384, 8'd16);
        do_load(1, 16'd4000, 16'd12000, 8'hF0);
        do_load(2, 16'hE000, 16'd8000, 8'd40);
        do_load(3, 16'd100, 16'hC000, 8'd3);
        do_run(3, 1'b0);

        // Zero-step run: done only
        do_run(0, 1'b0);

        // Load and start together: load only
        @(negedge clk);
        load = 1'b1; start = 1'b1; n_steps = 16'd5;
        load_ch = 2'd2; sin_y0 = 16'd777; cos_y0 = 16'd9999; k_in = 8'd25;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        ms[2] = 777; mc[2] = 9999; mk[2] = 25;
        chk("load_start_no_busy", longint'(busy), 0);
        @(negedge clk);
        chk("load_start_still_idle", longint'(busy), 0);

        // Load/start during a run are ignored; follow-up run exposes the state
        do_run(2, 1'b1);
        do_run(1, 1'b0);

        // Randomized loads and runs
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 1)
                    do_load(c, DW'($urandom), DW'($urandom), TW'($urandom));
            end
            do_run(int'($urandom_range(1, 4)), 1'b0);
        end

        // Reset in the middle of a run (step 2, ch 1)
        model_run(3);
        @(negedge clk);
        start = 1'b1; n_steps = 16'd3;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid && out_step == 16'd2 && out_ch == 2'd1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrun_point_reached", longint'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", longint'(busy), 0);
        chk("midrun_rst_done", longint'(done), 0);
        chk("midrun_rst_valid", longint'(out_valid), 0);
        chk("midrun_rst_sin", longint'(sin_y), 0);
        chk("midrun_rst_cos", longint'(cos_y), 0);
        chk("midrun_rst_ch", longint'(out_ch), 0);
        q.delete();
        for (int i = 0; i < NCH; i++) begin
            ms[i] = 0; mc[i] = 0; mk[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(1, 1'b0);
        chk("post_reset_sin", last0_s, 0);
        chk("post_reset_cos", last0_c, 0);

        // Long run: the discrete map keeps s^2+c^2 within k/(2-k) (about 3.2%) of
        // its start for k = 1/16; allow 4% around 2^28 to cover floor rounding.
        do_load(0, 16'd0, 16'd16384, 8'd16);
        amp_watch = 1'b1;
        do_run(1600, 1'b0);
        amp_watch = 1'b0;
        chk("long_amp_min_ok", longint'(amp_min >= 64'd257698038), 1);
        chk("long_amp_max_ok", longint'(amp_max <= 64'd279172874), 1);
        chk("long_no_saturation", longint'(sat_seen), 0);

        @(negedge clk);
        chk("scoreboard_drained", longint'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
